jtdd_sdram_sched: RTL and testbench
===================================

Name: jtdd_sdram_sched

Overview:
- Read scheduler sharing the single SDRAM read port between four byte-wide ROM requesters: main CPU, sound CPU, MCU and ADPCM.
- Each slot keeps a one-line, 32-bit cache and flags ok when the requested byte is in that cache.
- Misses are served by round-robin arbitration.
- Sits between the CPU/sound/MCU ROM address buses and the SDRAM controller; drives sdram_req, sdram_addr and refresh_en.

Parameters:
- AW, 18, byte-address width of every slot (unused upper bits tied low by the instantiator).
- OFFSET0, 22'h0_0000, SDRAM 16-bit-word offset added for slot 0.
- OFFSET1, 22'h1_4000, word offset for slot 1.
- OFFSET2, 22'h6_0000, word offset for slot 2.
- OFFSET3, 22'h1_8000, word offset for slot 3.

Ports:
- clk  in  1  system clock, 48 MHz.
- rstn  in  1  reset, asynchronous assertion, active-low.
- downloading  in  1  ROM download in progress.
- loop_rst  in  1  invalidates all caches.
- slotN_cs (N=0..3)  in  1  slot N request.
- slotN_addr (N=0..3)  in  AW  slot N byte address.
- slotN_ok (N=0..3)  out  1  slot N data valid for the current address.
- slotN_dout (N=0..3)  out  8  slot N byte.
- sdram_req  out  1  read request.
- sdram_addr  out  22  SDRAM word address.
- sdram_ack  in  1  request accepted.
- data_rdy  in  1  data_read valid.
- data_read  in  32  two SDRAM words.
- refresh_en  out  1  SDRAM refresh permitted.
- ready  out  1  scheduler operational.

Behaviour:
- Reset value of every output is 0, except refresh_en=1.
- Reset state: state=IDLE, all valid bits=0, all tags=0, rr_last=3 (slot 0 wins first).
- Cache per slot: 32-bit line, tag = addr[AW-1:2], valid bit.
- Hit condition: hit_N = valid_N && tag_N==slotN_addr[AW-1:2].
- slotN_ok = slotN_cs && hit_N, combinational. A hit therefore has zero latency, and a changed address drops ok in the same cycle.
- slotN_dout = line_N byte at slotN_addr[1:0], combinational; byte 0 = data_read[7:0], byte 3 = data_read[31:24].
- pend_N = slotN_cs && !hit_N && !downloading.
- FSM states: IDLE, WAIT_ACK, WAIT_RDY.
- IDLE: if any pend, grant the first pending slot searching from rr_last+1 modulo 4.
  - Latch gnt=N and req_tag=slotN_addr[AW-1:2].
  - Next cycle: sdram_req=1 and sdram_addr=OFFSETN + {req_tag,1'b0} (22-bit add, carry out discarded); rr_last<=N; go to WAIT_ACK.
- WAIT_ACK: hold sdram_req and sdram_addr stable until sdram_ack=1. The cycle after ack: sdram_req=0, go to WAIT_RDY.
- WAIT_RDY: on data_rdy=1, set line_gnt<=data_read, tag_gnt<=req_tag, valid_gnt<=1, go to IDLE.
  - Best-case miss-to-ok latency: 3 cycles plus SDRAM latency.
- Fill rule: a fill always uses the latched req_tag, even if the slot's cs or addr changed meanwhile. If the new address misses, a fresh request follows.
- Deasserting cs mid-transaction does not abort it.
- sdram_ack and data_rdy are ignored outside WAIT_ACK and WAIT_RDY respectively.
- Fairness: a slot with continuous misses cannot starve any other pending slot. Maximum wait is 3 transactions.
- loop_rst=1: clear all valid bits that cycle. An in-flight fill still completes and sets its valid bit if data_rdy arrives after loop_rst.
- downloading=1, from any state:
  - go to IDLE next cycle with sdram_req=0;
  - clear all valid bits;
  - no grants while high;
  - ready=0.
- refresh_en = (state==IDLE) && no pend_N, registered (one-cycle delay).
- ready: set to 1 on the first cycle with downloading=0 and state==IDLE after reset or after downloading falls. Sticky until rstn=0 or downloading=1.
- Asynchronous reset mid-transaction: all state cleared immediately; sdram_req=0 without waiting for ack.

Test Plan:
- Reset then idle:
  - rstn=0 → all ok=0, sdram_req=0, refresh_en=1.
  - Release with downloading=0 → ready=1 within 2 cycles.
- Single miss, then hit:
  - slot0_cs=1, addr=18'h00105 → sdram_req=1, sdram_addr=22'h000082.
  - Ack after 2 cycles, data_rdy with 32'hDDCCBBAA after 4 more → slot0_ok=1 with dout=8'hBB.
  - Change addr to 18'h00107 → ok stays 1, dout=8'hDD, no new request.
- Round-robin:
  - All four slots miss simultaneously → grant order 0,1,2,3.
  - Slot 0 misses again during the slot 1 transaction → served after slot 3.
  - sdram_addr for slot 2 with addr 0 is 22'h060000.
- Address change in flight:
  - slot1 addr 18'h00010 requested, then changed to 18'h00020 before data_rdy.
  - ok stays 0 after the fill, a second request at 22'h014010 follows, and ok rises after its fill.
- loop_rst and downloading:
  - loop_rst with a cached hit on slot 3 → slot3_ok falls the next cycle and a refetch is issued.
  - downloading=1 during WAIT_ACK → sdram_req=0 next cycle, ready=0, no grants until downloading falls.
- refresh_en:
  - No cs active → refresh_en=1.
  - Any miss pending → refresh_en=0 one cycle later, back to 1 one cycle after the final fill returns to IDLE.

Source files
------------

// File: rtl/jtdd_sdram_sched_if.sv
// SDRAM read-port bundle between the ROM read scheduler and the SDRAM controller.
// The scheduler owns the request side; the controller answers with ack/ready/data.
interface jtdd_sdram_sched_if;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_rdy;
    logic [31:0] data_read;
    logic        refresh_en;

    modport master (
        output sdram_req, sdram_addr, refresh_en,
        input  sdram_ack, data_rdy, data_read
    );

    modport slave (
        input  sdram_req, sdram_addr, refresh_en,
        output sdram_ack, data_rdy, data_read
    );
endinterface

// File: rtl/jtdd_sdram_sched.sv
// Four-slot ROM read scheduler: one 32-bit line cache per slot, round-robin miss service
// over a single SDRAM read port.
module jtdd_sdram_sched #(
    parameter int          AW      = 18,
    parameter logic [21:0] OFFSET0 = 22'h0_0000,
    parameter logic [21:0] OFFSET1 = 22'h1_4000,
    parameter logic [21:0] OFFSET2 = 22'h6_0000,
    parameter logic [21:0] OFFSET3 = 22'h1_8000
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          downloading,
    input  logic          loop_rst,
    input  logic          slot0_cs,
    input  logic          slot1_cs,
    input  logic          slot2_cs,
    input  logic          slot3_cs,
    input  logic [AW-1:0] slot0_addr,
    input  logic [AW-1:0] slot1_addr,
    input  logic [AW-1:0] slot2_addr,
    input  logic [AW-1:0] slot3_addr,
    output logic          slot0_ok,
    output logic          slot1_ok,
    output logic          slot2_ok,
    output logic          slot3_ok,
    output logic [7:0]    slot0_dout,
    output logic [7:0]    slot1_dout,
    output logic [7:0]    slot2_dout,
    output logic [7:0]    slot3_dout,
    output logic          ready,
    jtdd_sdram_sched_if.master sdram
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cs, hit, pend, valid;
    logic [AW-1:0] addr [4];
    logic [AW-3:0] tag  [4];
    logic [31:0]   line [4];
    logic [1:0]    rr_last, rr_idx, gnt, gnt_nxt;
    logic          gnt_found, fill;
    logic [AW-3:0] req_tag;
    logic          req_q, refresh_q;
    logic [21:0]   addr_q, addr_nxt;

    function automatic logic [21:0] slot_offset(input logic [1:0] s);
        case (s)
            2'd0:    return OFFSET0;
            2'd1:    return OFFSET1;
            2'd2:    return OFFSET2;
            default: return OFFSET3;
        endcase
    endfunction

    assign cs      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
    assign addr[0] = slot0_addr;
    assign addr[1] = slot1_addr;
    assign addr[2] = slot2_addr;
    assign addr[3] = slot3_addr;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        hit  = '0;
        pend = '0;
        for (int i = 0; i < 4; i++) begin
            hit[i]  = valid[i] && (tag[i] == addr[i][AW-1:2]);
            pend[i] = cs[i] && !hit[i] && !downloading;
        end
    end

    assign slot0_ok   = cs[0] && hit[0];
    assign slot1_ok   = cs[1] && hit[1];
    assign slot2_ok   = cs[2] && hit[2];
    assign slot3_ok   = cs[3] && hit[3];
    assign slot0_dout = line[0][{slot0_addr[1:0], 3'b000} +: 8];
    assign slot1_dout = line[1][{slot1_addr[1:0], 3'b000} +: 8];
    assign slot2_dout = line[2][{slot2_addr[1:0], 3'b000} +: 8];
    assign slot3_dout = line[3][{slot3_addr[1:0], 3'b000} +: 8];

    // Search starts one past the last winner, so a busy slot cannot starve the rest.
    always_comb begin
        gnt_found = 1'b0;
        gnt_nxt   = rr_last;
        rr_idx    = rr_last;
        for (int k = 1; k <= 4; k++) begin
            rr_idx = rr_last + 2'(k);
            if (!gnt_found && pend[rr_idx]) begin
                gnt_found = 1'b1;
                gnt_nxt   = rr_idx;
            end
        end
        addr_nxt = slot_offset(gnt_nxt) + 22'({addr[gnt_nxt][AW-1:2], 1'b0});
    end

    always_comb begin
        state_nxt = state;
        if (downloading) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (gnt_found)       state_nxt = WAIT_ACK;
                WAIT_ACK: if (sdram.sdram_ack) state_nxt = WAIT_RDY;
                WAIT_RDY: if (sdram.data_rdy)  state_nxt = IDLE;
                default:                       state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: all sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_last   <= 2'd3;
            gnt       <= 2'd0;
            req_tag   <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            refresh_q <= 1'b1;
            ready     <= 1'b0;
        end else begin
            refresh_q <= (state == IDLE) && (pend == 4'd0);
            ready     <= !downloading && (ready || state == IDLE);
            if (downloading) begin
                req_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (gnt_found) begin
                        gnt     <= gnt_nxt;
                        req_tag <= addr[gnt_nxt][AW-1:2];
                        rr_last <= gnt_nxt;
                        req_q   <= 1'b1;
                        addr_q  <= addr_nxt;
                    end
                    WAIT_ACK: if (sdram.sdram_ack) req_q <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign fill = (state == WAIT_RDY) && sdram.data_rdy && !downloading;

    // NOTE: the line storage is reset along with tags so slot bytes read 0 out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= '0;
            for (int i = 0; i < 4; i++) begin
                line[i] <= '0;
                tag[i]  <= '0;
            end
        end else begin
            if (downloading || loop_rst) valid <= '0;
            // A fill landing with loop_rst still marks its own line valid.
            if (fill) begin
                line[gnt]  <= sdram.data_read;
                tag[gnt]   <= req_tag;
                valid[gnt] <= 1'b1;
            end
        end
    end

    assign sdram.sdram_req  = req_q;
    assign sdram.sdram_addr = addr_q;
    assign sdram.refresh_en = refresh_q;
endmodule

// File: tb/tb_jtdd_sdram_sched.sv
// Directed bench for jtdd_sdram_sched: each task drives one scenario and checks inline
// against hand-computed addresses, bytes and flags.
module tb_jtdd_sdram_sched;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        downloading = 1'b0;
    logic        loop_rst = 1'b0;
    logic        slot0_cs = 1'b0, slot1_cs = 1'b0, slot2_cs = 1'b0, slot3_cs = 1'b0;
    logic [17:0] slot0_addr = '0, slot1_addr = '0, slot2_addr = '0, slot3_addr = '0;
    logic        slot0_ok, slot1_ok, slot2_ok, slot3_ok;
    logic [7:0]  slot0_dout, slot1_dout, slot2_dout, slot3_dout;
    logic        ready;
    int          checks = 0;
    int          errors = 0;

    jtdd_sdram_sched_if bus ();

    jtdd_sdram_sched dut (
        .clk(clk), .rstn(rstn), .downloading(downloading), .loop_rst(loop_rst),
        .slot0_cs(slot0_cs), .slot1_cs(slot1_cs), .slot2_cs(slot2_cs), .slot3_cs(slot3_cs),
        .slot0_addr(slot0_addr), .slot1_addr(slot1_addr),
        .slot2_addr(slot2_addr), .slot3_addr(slot3_addr),
        .slot0_ok(slot0_ok), .slot1_ok(slot1_ok), .slot2_ok(slot2_ok), .slot3_ok(slot3_ok),
        .slot0_dout(slot0_dout), .slot1_dout(slot1_dout),
        .slot2_dout(slot2_dout), .slot3_dout(slot3_dout),
        .ready(ready), .sdram(bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        bus.data_read = '0;
    end

    task automatic wait_req(input logic [21:0] exp, input string name);
        int n = 0;
        while (!bus.sdram_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.sdram_req) begin
            errors++;
            $display("FAIL %s: no sdram_req within 20 cycles", name);
        end else if (bus.sdram_addr !== exp) begin
            errors++;
            $display("FAIL %s: sdram_addr=%h expected %h", name, bus.sdram_addr, exp);
        end
    endtask

    task automatic do_ack(input int dly, input logic [21:0] exp, input string name);
        repeat (dly) @(negedge clk);
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== exp) begin
            errors++;
            $display("FAIL %s_hold: req=%b addr=%h expected req=1 addr=%h",
                     name, bus.sdram_req, bus.sdram_addr, exp);
        end
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        checks++;
        if (bus.sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_drop: sdram_req=%b expected 0 after ack", name, bus.sdram_req);
        end
    endtask

    task automatic do_rdy(input int dly, input logic [31:0] data);
        repeat (dly) @(negedge clk);
        bus.data_rdy  = 1'b1;
        bus.data_read = data;
        @(negedge clk);
        bus.data_rdy  = 1'b0;
    endtask

    task automatic serve(input logic [21:0] exp, input logic [31:0] data, input string name);
        wait_req(exp, name);
        do_ack(1, exp, name);
        do_rdy(1, data);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({slot3_ok, slot2_ok, slot1_ok, slot0_ok} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ok: ok=%b expected 0000", {slot3_ok, slot2_ok, slot1_ok, slot0_ok});
        end
        checks++;
        if (bus.sdram_req !== 1'b0 || bus.sdram_addr !== 22'h0) begin
            errors++;
            $display("FAIL reset_req: req=%b addr=%h expected 0/0", bus.sdram_req, bus.sdram_addr);
        end
        checks++;
        if (bus.refresh_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_refresh: refresh_en=%b expected 1", bus.refresh_en);
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: ready=%b expected 0", ready);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_rise: ready=%b expected 1", ready);
        end
    endtask

    task automatic test_async_reset;
        slot0_cs   = 1'b1;
        slot0_addr = 18'h00600;
        wait_req(22'h000300, "areset_req");
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (bus.sdram_req !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_clear: req=%b ready=%b expected 0/0", bus.sdram_req, ready);
        end
        slot0_cs = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.sdram_req !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_idle: req=%b ready=%b expected 0/1", bus.sdram_req, ready);
        end
    endtask

    task automatic test_round_robin;
        slot0_addr = 18'h00200; slot1_addr = 18'h00300;
        slot2_addr = 18'h00000; slot3_addr = 18'h00400;
        {slot3_cs, slot2_cs, slot1_cs, slot0_cs} = 4'b1111;
        serve(22'h000100, 32'h03020100, "rr_slot0");
        @(negedge clk);
        slot0_addr = 18'h00204;
        serve(22'h014180, 32'h13121110, "rr_slot1");
        serve(22'h060000, 32'h23222120, "rr_slot2");
        serve(22'h018200, 32'h33323130, "rr_slot3");
        serve(22'h000102, 32'h43424140, "rr_slot0_again");
        checks++;
        if ({slot3_ok, slot2_ok, slot1_ok, slot0_ok} !== 4'b1111) begin
            errors++;
            $display("FAIL rr_all_ok: ok=%b expected 1111", {slot3_ok, slot2_ok, slot1_ok, slot0_ok});
        end
        checks++;
        if (slot2_dout !== 8'h20 || slot0_dout !== 8'h40) begin
            errors++;
            $display("FAIL rr_dout: slot2=%h slot0=%h expected 20/40", slot2_dout, slot0_dout);
        end
        {slot2_cs, slot1_cs, slot0_cs} = 3'b000;
        slot3_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_miss;
        slot0_cs   = 1'b1;
        slot0_addr = 18'h00105;
        #1;
        checks++;
        if (slot0_ok !== 1'b0) begin
            errors++;
            $display("FAIL miss_ok_low: slot0_ok=%b expected 0", slot0_ok);
        end
        wait_req(22'h000082, "miss_req");
        do_ack(2, 22'h000082, "miss");
        do_rdy(4, 32'hDDCCBBAA);
        checks++;
        if (slot0_ok !== 1'b1 || slot0_dout !== 8'hBB) begin
            errors++;
            $display("FAIL miss_fill: ok=%b dout=%h expected 1/BB", slot0_ok, slot0_dout);
        end
        slot0_addr = 18'h00107;
        #1;
        checks++;
        if (slot0_ok !== 1'b1 || slot0_dout !== 8'hDD) begin
            errors++;
            $display("FAIL hit_byte3: ok=%b dout=%h expected 1/DD", slot0_ok, slot0_dout);
        end
        begin
            logic seen = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (bus.sdram_req) seen = 1'b1;
            end
            checks++;
            if (seen !== 1'b0) begin
                errors++;
                $display("FAIL hit_no_req: sdram_req seen=%b expected 0", seen);
            end
        end
        slot0_cs = 1'b0;
    endtask

    task automatic test_addr_change;
        slot1_cs   = 1'b1;
        slot1_addr = 18'h00010;
        wait_req(22'h014008, "chg_req1");
        do_ack(1, 22'h014008, "chg1");
        slot1_addr = 18'h00020;
        do_rdy(2, 32'h55555555);
        checks++;
        if (slot1_ok !== 1'b0) begin
            errors++;
            $display("FAIL chg_stale: slot1_ok=%b expected 0", slot1_ok);
        end
        serve(22'h014010, 32'h66676869, "chg_req2");
        checks++;
        if (slot1_ok !== 1'b1 || slot1_dout !== 8'h69) begin
            errors++;
            $display("FAIL chg_fill: ok=%b dout=%h expected 1/69", slot1_ok, slot1_dout);
        end
        slot1_cs = 1'b0;
    endtask

    task automatic test_loop_rst;
        slot3_cs   = 1'b1;
        slot3_addr = 18'h00400;
        #1;
        checks++;
        if (slot3_ok !== 1'b1 || slot3_dout !== 8'h30) begin
            errors++;
            $display("FAIL lrst_hit: ok=%b dout=%h expected 1/30", slot3_ok, slot3_dout);
        end
        loop_rst = 1'b1;
        @(negedge clk);
        loop_rst = 1'b0;
        checks++;
        if (slot3_ok !== 1'b0) begin
            errors++;
            $display("FAIL lrst_drop: slot3_ok=%b expected 0", slot3_ok);
        end
        serve(22'h018200, 32'h77777777, "lrst_refetch");
        checks++;
        if (slot3_ok !== 1'b1 || slot3_dout !== 8'h77) begin
            errors++;
            $display("FAIL lrst_fill: ok=%b dout=%h expected 1/77", slot3_ok, slot3_dout);
        end
    endtask

    task automatic test_downloading;
        slot2_cs   = 1'b1;
        slot2_addr = 18'h00008;
        wait_req(22'h060004, "dl_req");
        downloading = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.sdram_req !== 1'b0 || ready !== 1'b0 || slot3_ok !== 1'b0) begin
            errors++;
            $display("FAIL dl_abort: req=%b ready=%b slot3_ok=%b expected 0/0/0",
                     bus.sdram_req, ready, slot3_ok);
        end
        begin
            logic seen = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (bus.sdram_req) seen = 1'b1;
            end
            checks++;
            if (seen !== 1'b0) begin
                errors++;
                $display("FAIL dl_no_grant: sdram_req seen=%b expected 0", seen);
            end
        end
        downloading = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL dl_ready: ready=%b expected 1", ready);
        end
        serve(22'h018200, 32'h88888888, "dl_slot3");
        serve(22'h060004, 32'h99999999, "dl_slot2");
        {slot3_cs, slot2_cs} = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_refresh;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.refresh_en !== 1'b1) begin
            errors++;
            $display("FAIL ref_idle: refresh_en=%b expected 1", bus.refresh_en);
        end
        slot0_cs   = 1'b1;
        slot0_addr = 18'h00500;
        @(negedge clk);
        checks++;
        if (bus.refresh_en !== 1'b0) begin
            errors++;
            $display("FAIL ref_pend: refresh_en=%b expected 0", bus.refresh_en);
        end
        serve(22'h000280, 32'hAAAAAAAA, "ref_req");
        checks++;
        if (bus.refresh_en !== 1'b0) begin
            errors++;
            $display("FAIL ref_fill: refresh_en=%b expected 0", bus.refresh_en);
        end
        @(negedge clk);
        checks++;
        if (bus.refresh_en !== 1'b1) begin
            errors++;
            $display("FAIL ref_back: refresh_en=%b expected 1", bus.refresh_en);
        end
        slot0_cs = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_async_reset();
        test_round_robin();
        test_single_miss();
        test_addr_change();
        test_loop_rst();
        test_downloading();
        test_refresh();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
